// File: rtl/arbiter_2ph_pkg.sv
// Shared types for the two-phase mutual-exclusion arbiter.
//   state_t    : arbiter FSM states
//   port_idx_t : priority pointer, 0 selects port 1, 1 selects port 2
package arbiter_2ph_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT1 = 2'd1,
        GRANT2 = 2'd2
    } state_t;

    typedef logic port_idx_t;

    localparam port_idx_t PORT1 = 1'b0;
    localparam port_idx_t PORT2 = 1'b1;

endpackage

// File: rtl/sync_2ph_bit.sv
// N-stage flip-flop synchronizer for one two-phase signal.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset, clears every stage
//   din  : asynchronous input level
//   dout : synchronized level, N cycles behind din
module sync_2ph_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] stage_r;

    // Shift the input level through the synchronizer chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_r <= {STAGES{1'b0}};
        end else begin
            stage_r <= {stage_r[STAGES-2:0], din};
        end
    end

    assign dout = stage_r[STAGES-1];

endmodule

// File: rtl/arbiter_2ph.sv
// Clocked two-input two-phase mutual-exclusion arbiter with round-robin
// tie breaking. Exactly one grant is outstanding at a time.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   r1/a1    : port-1 request / acknowledge (pending when r1 != a1)
//   r2/a2    : port-2 request / acknowledge
//   g1/d1    : channel-1 grant / done       (busy when g1 != d1)
//   g2/d2    : channel-2 grant / done
// All outputs come straight from flops.
module arbiter_2ph
    import arbiter_2ph_pkg::*;
#(
    parameter int SYNC_STAGES = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic r1,
    output logic a1,
    input  logic r2,
    output logic a2,
    output logic g1,
    input  logic d1,
    output logic g2,
    input  logic d2
);

    logic r1_s, r2_s, d1_s, d2_s;

    state_t    state_r, state_nxt_s;
    port_idx_t prio_r, prio_nxt_s;
    logic      a1_r, a2_r, g1_r, g2_r;
    logic      a1_nxt_s, a2_nxt_s, g1_nxt_s, g2_nxt_s;
    logic      pend1_s, pend2_s;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign r1_s = r1;
            assign r2_s = r2;
            assign d1_s = d1;
            assign d2_s = d2;
        end else begin : g_sync
            sync_2ph_bit #(.STAGES(SYNC_STAGES)) u_sync_r1 (.clk(clk), .rst(rst), .din(r1), .dout(r1_s));
            sync_2ph_bit #(.STAGES(SYNC_STAGES)) u_sync_r2 (.clk(clk), .rst(rst), .din(r2), .dout(r2_s));
            sync_2ph_bit #(.STAGES(SYNC_STAGES)) u_sync_d1 (.clk(clk), .rst(rst), .din(d1), .dout(d1_s));
            sync_2ph_bit #(.STAGES(SYNC_STAGES)) u_sync_d2 (.clk(clk), .rst(rst), .din(d2), .dout(d2_s));
        end
    endgenerate

    assign pend1_s = r1_s ^ a1_r;
    assign pend2_s = r2_s ^ a2_r;

    // State, priority pointer and handshake output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            prio_r  <= PORT1;
            a1_r    <= 1'b0;
            a2_r    <= 1'b0;
            g1_r    <= 1'b0;
            g2_r    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            prio_r  <= prio_nxt_s;
            a1_r    <= a1_nxt_s;
            a2_r    <= a2_nxt_s;
            g1_r    <= g1_nxt_s;
            g2_r    <= g2_nxt_s;
        end
    end

    // Arbitration decision and handshake toggles.
    always_comb begin
        state_nxt_s = state_r;
        prio_nxt_s  = prio_r;
        a1_nxt_s    = a1_r;
        a2_nxt_s    = a2_r;
        g1_nxt_s    = g1_r;
        g2_nxt_s    = g2_r;
        case (state_r)
            IDLE: begin
                // Port 1 wins when alone, or on a tie while it holds priority.
                if (pend1_s && (!pend2_s || (prio_r == PORT1))) begin
                    g1_nxt_s    = ~g1_r;
                    state_nxt_s = GRANT1;
                end else if (pend2_s) begin
                    g2_nxt_s    = ~g2_r;
                    state_nxt_s = GRANT2;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            GRANT1: begin
                // Done has caught up with the grant: channel 1 is free again.
                if (d1_s == g1_r) begin
                    a1_nxt_s    = ~a1_r;
                    prio_nxt_s  = PORT2;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = GRANT1;
                end
            end
            GRANT2: begin
                if (d2_s == g2_r) begin
                    a2_nxt_s    = ~a2_r;
                    prio_nxt_s  = PORT1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = GRANT2;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    assign a1 = a1_r;
    assign a2 = a2_r;
    assign g1 = g1_r;
    assign g2 = g2_r;

endmodule

// File: tb/tb_arbiter_2ph.sv
// Self-checking bench for arbiter_2ph: directed test-plan steps followed by
// random protocol-obeying traffic, all checked against a transaction-count
// model of the arbiter. A second instance with SYNC_STAGES=2 checks the
// added synchronizer latency.
module tb_arbiter_2ph;
    import arbiter_2ph_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic r1, r2, d1, d2;
    logic a1, a2, g1, g2;
    logic sr1, sr2, sd1, sd2;
    logic sa1, sa2, sg1, sg2;

    int checks   = 0;
    int failures = 0;

    // Reference model: counts of grants/acks per port, current owner, last served.
    int gc1, gc2, ac1, ac2;
    int owner;      // 0 none, 1 or 2
    int last_srv;   // port served most recently (loses ties)

    always #5 clk = ~clk;

    arbiter_2ph #(.SYNC_STAGES(0)) dut (
        .clk(clk), .rst(rst),
        .r1(r1), .a1(a1), .r2(r2), .a2(a2),
        .g1(g1), .d1(d1), .g2(g2), .d2(d2)
    );

    arbiter_2ph #(.SYNC_STAGES(2)) dut_sync (
        .clk(clk), .rst(rst),
        .r1(sr1), .a1(sa1), .r2(sr2), .a2(sa2),
        .g1(sg1), .d1(sd1), .g2(sg2), .d2(sd2)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One clock: update the model from the inputs seen at the edge, then compare.
    task automatic tick();
        bit p1, p2;
        @(posedge clk);
        if (rst) begin
            gc1 = 0; gc2 = 0; ac1 = 0; ac2 = 0;
            owner = 0; last_srv = 2;
        end else if (owner == 0) begin
            p1 = (r1 != ac1[0]);
            p2 = (r2 != ac2[0]);
            if (p1 && (!p2 || last_srv == 2)) begin
                gc1++; owner = 1;
            end else if (p2) begin
                gc2++; owner = 2;
            end
        end else if (owner == 1) begin
            if (d1 == gc1[0]) begin
                ac1++; last_srv = 1; owner = 0;
            end
        end else begin
            if (d2 == gc2[0]) begin
                ac2++; last_srv = 2; owner = 0;
            end
        end
        #1;
        chk("model_g1", g1, gc1[0]);
        chk("model_g2", g2, gc2[0]);
        chk("model_a1", a1, ac1[0]);
        chk("model_a2", a2, ac2[0]);
        chk("mutex", (g1 ^ d1) & (g2 ^ d2), 1'b0);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        r1 = 1'b0; r2 = 1'b0; d1 = 1'b0; d2 = 1'b0;
        sr1 = 1'b0; sr2 = 1'b0; sd1 = 1'b0; sd2 = 1'b0;
        for (int i = 0; i < cycles; i++) tick();
        rst = 1'b0;
    endtask

    initial begin
        // Reset
        do_reset(2);
        chk("rst_g1", g1, 1'b0);
        chk("rst_g2", g2, 1'b0);
        chk("rst_a1", a1, 1'b0);
        chk("rst_a2", a2, 1'b0);
        chk("rst_idle", dut.state_r == IDLE, 1'b1);

        // Single port-1 transaction
        r1 = 1'b1; tick();
        chk("p1_grant", g1, 1'b1);
        chk("p1_noack", a1, 1'b0);
        tick(); tick();
        d1 = 1'b1; tick();
        chk("p1_ack", a1, 1'b1);
        chk("p1_g2", g2, 1'b0);
        chk("p1_a2", a2, 1'b0);

        // Round-robin tie: port 1 served last, so port 2 wins
        r1 = 1'b0; r2 = 1'b1; tick();
        chk("rr_g2_first", g2, 1'b1);
        chk("rr_g1_hold", g1, 1'b1);
        d2 = 1'b1; tick();
        chk("rr_a2", a2, 1'b1);
        tick();
        chk("rr_g1_next", g1, 1'b0);
        d1 = 1'b0; tick();
        chk("rr_a1", a1, 1'b0);

        // Simultaneous requests right after reset: port 1 first
        do_reset(1);
        r1 = 1'b1; r2 = 1'b1; tick();
        chk("sim_g1", g1, 1'b1);
        chk("sim_g2_hold", g2, 1'b0);
        d1 = 1'b1; tick();
        chk("sim_a1", a1, 1'b1);
        chk("sim_g2_wait", g2, 1'b0);
        tick();
        chk("sim_g2", g2, 1'b1);
        d2 = 1'b1; tick();
        chk("sim_a2", a2, 1'b1);

        // Port 2 arrives during a port-1 grant
        r1 = 1'b0; tick();
        chk("ovl_g1", g1, 1'b0);
        r2 = 1'b0; tick();
        chk("ovl_g2_hold0", g2, 1'b1);
        tick();
        chk("ovl_g2_hold1", g2, 1'b1);
        d1 = 1'b0; tick();
        chk("ovl_a1", a1, 1'b0);
        chk("ovl_g2_hold2", g2, 1'b1);
        tick();
        chk("ovl_g2_served", g2, 1'b0);
        d2 = 1'b0; tick();
        chk("ovl_a2", a2, 1'b0);

        // Reset in the middle of a port-1 grant
        r1 = 1'b1; tick();
        chk("mid_g1", g1, 1'b1);
        do_reset(1);
        chk("mid_rst_g1", g1, 1'b0);
        chk("mid_rst_a1", a1, 1'b0);
        chk("mid_rst_idle", dut.state_r == IDLE, 1'b1);
        r2 = 1'b1; tick();
        chk("mid_p2_grant", g2, 1'b1);
        d2 = 1'b1; tick();
        chk("mid_p2_ack", a2, 1'b1);

        // Two synchronizer stages: grant and ack each appear two edges later
        do_reset(2);
        sr1 = 1'b1;
        tick(); chk("sync_g1_e1", sg1, 1'b0);
        tick(); chk("sync_g1_e2", sg1, 1'b0);
        tick(); chk("sync_g1_e3", sg1, 1'b1);
        chk("sync_a1_pre", sa1, 1'b0);
        tick(); tick();
        sd1 = 1'b1;
        tick(); chk("sync_a1_e1", sa1, 1'b0);
        tick(); chk("sync_a1_e2", sa1, 1'b0);
        tick(); chk("sync_a1_e3", sa1, 1'b1);
        chk("sync_g2", sg2, 1'b0);

        // Random traffic from well-behaved requesters and channels
        do_reset(2);
        for (int i = 0; i < 600; i++) begin
            if (r1 == a1 && $urandom_range(0, 2) == 0) r1 = ~r1;
            if (r2 == a2 && $urandom_range(0, 2) == 0) r2 = ~r2;
            if (g1 != d1 && $urandom_range(0, 3) == 0) d1 = ~d1;
            if (g2 != d2 && $urandom_range(0, 3) == 0) d2 = ~d2;
            tick();
        end
        chk("rand_progress", (ac1 > 10) && (ac2 > 10), 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
